// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush scheduler: merges stall sources into one hold level, forwards jumps,
// sequences post-jump flushes and debug halt. Optional watchdog with `define PIPE_HOLD_WDOG_EN.
module pipe_hold_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_LIMIT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_ex_i,
    input  logic        hold_flag_rib_i,
    input  logic        hold_flag_clint_i,
    input  logic        halt_req_i,
    input  logic [4:0]  id_rs1_raddr_i,
    input  logic [4:0]  id_rs2_raddr_i,
    input  logic        ex_reg_we_i,
    input  logic [4:0]  ex_reg_waddr_i,
    input  logic        ex_is_load_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        halted_o,
    output logic [31:0] stall_cnt_o
`ifdef PIPE_HOLD_WDOG_EN
    ,
    output logic        wdog_o
`endif
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || WDOG_LIMIT < 1 || WDOG_LIMIT > 65535) begin : g_bad_param
            $error("pipe_hold_ctrl: FLUSH_CYCLES must be 1..15 and WDOG_LIMIT 1..65535");
        end
    endgenerate

    logic [1:0]  r_state;
    logic [3:0]  r_flush_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_load_use;
    logic [2:0]  w_req;
    logic [2:0]  w_hold;

    assign w_load_use = ex_is_load_i & ex_reg_we_i & (ex_reg_waddr_i != 5'd0) &
                        ((ex_reg_waddr_i == id_rs1_raddr_i) | (ex_reg_waddr_i == id_rs2_raddr_i));

    always_comb begin
        w_req = HOLD_NONE;
        if (jump_flag_i | hold_flag_ex_i | hold_flag_clint_i | w_load_use)
            w_req = HOLD_ID;
        else if (hold_flag_rib_i)
            w_req = HOLD_PC;
    end

    always_comb begin
        w_hold = HOLD_ID;
        if (r_state == ST_RUN)
            w_hold = w_req;
    end

    assign hold_flag_o = w_hold;
    assign jump_flag_o = jump_flag_i;
    assign jump_addr_o = jump_flag_i ? jump_addr_i : 32'd0;
    assign halted_o    = (r_state == ST_HALT);
    assign stall_cnt_o = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 4'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_hold != HOLD_NONE && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            case (r_state)
                ST_RUN: begin
                    if (jump_flag_i) begin
                        if (FLUSH_CYCLES > 1) begin
                            r_state     <= ST_FLUSH;
                            r_flush_cnt <= FLUSH_RELOAD;
                        end
                    end else if (halt_req_i) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_FLUSH: begin
                    if (jump_flag_i) begin
                        r_flush_cnt <= FLUSH_RELOAD;
                    end else if (r_flush_cnt == 4'd1) begin
                        // Go straight to HALT so no instruction slips through between flush and halt.
                        r_state     <= halt_req_i ? ST_HALT : ST_RUN;
                        r_flush_cnt <= 4'd0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                ST_HALT: begin
                    if (!halt_req_i)
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef PIPE_HOLD_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT - 1);

    logic [15:0] r_wdog_cnt;
    logic        w_wdog_active;

    assign w_wdog_active = (w_hold != HOLD_NONE) && (r_state != ST_HALT);
    assign wdog_o        = w_wdog_active && (r_wdog_cnt == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (rst || !w_wdog_active || r_wdog_cnt == WDOG_LAST)
            r_wdog_cnt <= 16'd0;
        else
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Scoreboard bench for pipe_hold_ctrl (FLUSH_CYCLES=3); driver queues expected outputs per cycle,
// a negedge monitor pops and compares. Watchdog vectors run when PIPE_HOLD_WDOG_EN is defined.
module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_ex_i;
    logic        hold_flag_rib_i;
    logic        hold_flag_clint_i;
    logic        halt_req_i;
    logic [4:0]  id_rs1_raddr_i;
    logic [4:0]  id_rs2_raddr_i;
    logic        ex_reg_we_i;
    logic [4:0]  ex_reg_waddr_i;
    logic        ex_is_load_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        halted_o;
    logic [31:0] stall_cnt_o;
`ifdef PIPE_HOLD_WDOG_EN
    logic        wdog_o;
`endif

    always #5 clk = ~clk;

    pipe_hold_ctrl #(
        .FLUSH_CYCLES(3),
        .WDOG_LIMIT  (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .jump_flag_i      (jump_flag_i),
        .jump_addr_i      (jump_addr_i),
        .hold_flag_ex_i   (hold_flag_ex_i),
        .hold_flag_rib_i  (hold_flag_rib_i),
        .hold_flag_clint_i(hold_flag_clint_i),
        .halt_req_i       (halt_req_i),
        .id_rs1_raddr_i   (id_rs1_raddr_i),
        .id_rs2_raddr_i   (id_rs2_raddr_i),
        .ex_reg_we_i      (ex_reg_we_i),
        .ex_reg_waddr_i   (ex_reg_waddr_i),
        .ex_is_load_i     (ex_is_load_i),
        .hold_flag_o      (hold_flag_o),
        .jump_flag_o      (jump_flag_o),
        .jump_addr_o      (jump_addr_o),
        .halted_o         (halted_o),
        .stall_cnt_o      (stall_cnt_o)
`ifdef PIPE_HOLD_WDOG_EN
        ,
        .wdog_o           (wdog_o)
`endif
    );

    typedef struct {
        string       name;
        logic [2:0]  hold;
        logic        jf;
        logic [31:0] ja;
        logic        halted;
        logic        chk_stall;
        logic [31:0] stall;
        logic        wdog;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: outputs are valid every cycle, so one queued expectation per negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (hold_flag_o !== e.hold || jump_flag_o !== e.jf || jump_addr_o !== e.ja ||
                halted_o !== e.halted || (e.chk_stall && stall_cnt_o !== e.stall)) begin
                n_fail++;
                $display("FAIL %s: got hold=%0d jf=%0b ja=%h halted=%0b stall=%0d, want hold=%0d jf=%0b ja=%h halted=%0b stall=%0d%s",
                         e.name, hold_flag_o, jump_flag_o, jump_addr_o, halted_o, stall_cnt_o,
                         e.hold, e.jf, e.ja, e.halted, e.stall, e.chk_stall ? "" : "(unchecked)");
            end else begin
                $display("[TB] %s ok hold=%0d jf=%0b ja=%h halted=%0b stall=%0d",
                         e.name, hold_flag_o, jump_flag_o, jump_addr_o, halted_o, stall_cnt_o);
            end
`ifdef PIPE_HOLD_WDOG_EN
            n_tests++;
            if (wdog_o !== e.wdog) begin
                n_fail++;
                $display("FAIL %s wdog: got %0b want %0b", e.name, wdog_o, e.wdog);
            end
`endif
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'd0;
        hold_flag_ex_i = 1'b0; hold_flag_rib_i = 1'b0; hold_flag_clint_i = 1'b0;
        halt_req_i = 1'b0; id_rs1_raddr_i = 5'd0; id_rs2_raddr_i = 5'd0;
        ex_reg_we_i = 1'b0; ex_reg_waddr_i = 5'd0; ex_is_load_i = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [2:0] hold, input logic jf,
                              input logic [31:0] ja, input logic halted, input int stall,
                              input logic wdog = 1'b0);
        exp_t e;
        e.name = name; e.hold = hold; e.jf = jf; e.ja = ja; e.halted = halted;
        e.chk_stall = (stall >= 0); e.stall = 32'(stall); e.wdog = wdog;
        exp_q.push_back(e);
    endtask

    initial begin
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b1;
        nxt();                                        expect_out("reset",        3'd0, 0, 32'h0,   0, 0);

        // Jump with a 3-cycle flush
        nxt(); jump_flag_i = 1; jump_addr_i = 32'h100; expect_out("jump",        3'd3, 1, 32'h100, 0, 0);
        nxt();                                        expect_out("flush1",       3'd3, 0, 32'h0,   0, 1);
        nxt();                                        expect_out("flush2",       3'd3, 0, 32'h0,   0, 2);
        nxt();                                        expect_out("flush_done",   3'd0, 0, 32'h0,   0, 3);
        nxt(); jump_addr_i = 32'hDEAD;                expect_out("addr_gated",   3'd0, 0, 32'h0,   0, 3);

        // Load-use hazard
        nxt(); ex_is_load_i = 1; ex_reg_we_i = 1; ex_reg_waddr_i = 5; id_rs2_raddr_i = 5;
                                                      expect_out("lu_rs2",       3'd3, 0, 32'h0,   0, 3);
        nxt();                                        expect_out("lu_bubble",    3'd0, 0, 32'h0,   0, 4);
        nxt(); ex_is_load_i = 1; ex_reg_we_i = 1;     expect_out("lu_x0",        3'd0, 0, 32'h0,   0, 4);
        nxt(); ex_is_load_i = 1; ex_reg_we_i = 1; ex_reg_waddr_i = 5; id_rs1_raddr_i = 5;
                                                      expect_out("lu_rs1",       3'd3, 0, 32'h0,   0, 4);
        nxt(); ex_reg_we_i = 1; ex_reg_waddr_i = 5; id_rs1_raddr_i = 5;
                                                      expect_out("no_load",      3'd0, 0, 32'h0,   0, 5);

        // Bus hold with EX busy in the middle, then clint
        nxt(); hold_flag_rib_i = 1;                   expect_out("rib1",         3'd1, 0, 32'h0,   0, 5);
        nxt(); hold_flag_rib_i = 1; hold_flag_ex_i = 1; expect_out("rib2_ex",    3'd3, 0, 32'h0,   0, 6);
        nxt(); hold_flag_rib_i = 1;                   expect_out("rib3",         3'd1, 0, 32'h0,   0, 7);
        nxt(); hold_flag_rib_i = 1;                   expect_out("rib4",         3'd1, 0, 32'h0,   0, 8);
        nxt();                                        expect_out("rib_end",      3'd0, 0, 32'h0,   0, 9);
        nxt(); hold_flag_clint_i = 1;                 expect_out("clint",        3'd3, 0, 32'h0,   0, 9);
        nxt();                                        expect_out("clint_end",    3'd0, 0, 32'h0,   0, 10);

        // Debug halt for 5 cycles
        nxt(); halt_req_i = 1;                        expect_out("halt_c1",      3'd0, 0, 32'h0,   0, 10);
        nxt(); halt_req_i = 1;                        expect_out("halt_c2",      3'd3, 0, 32'h0,   1, 10);
        nxt(); halt_req_i = 1;                        expect_out("halt_c3",      3'd3, 0, 32'h0,   1, 11);
        nxt(); halt_req_i = 1;                        expect_out("halt_c4",      3'd3, 0, 32'h0,   1, 12);
        nxt(); halt_req_i = 1;                        expect_out("halt_c5",      3'd3, 0, 32'h0,   1, 13);
        nxt();                                        expect_out("halt_release", 3'd3, 0, 32'h0,   1, 14);
        nxt();                                        expect_out("halt_run",     3'd0, 0, 32'h0,   0, 15);

        // Jump seen during HALT: forwarded, HALT kept
        nxt(); halt_req_i = 1;                        expect_out("hj_enter",     3'd0, 0, 32'h0,   0, 15);
        nxt(); halt_req_i = 1; jump_flag_i = 1; jump_addr_i = 32'h200;
                                                      expect_out("hj_jump",      3'd3, 1, 32'h200, 1, 15);
        nxt();                                        expect_out("hj_release",   3'd3, 0, 32'h0,   1, 16);
        nxt();                                        expect_out("hj_run",       3'd0, 0, 32'h0,   0, 17);

        // Simultaneous jump and halt: flush first, then halt
        nxt(); halt_req_i = 1; jump_flag_i = 1; jump_addr_i = 32'h300;
                                                      expect_out("jh_jump",      3'd3, 1, 32'h300, 0, 17);
        nxt(); halt_req_i = 1;                        expect_out("jh_flush1",    3'd3, 0, 32'h0,   0, 18);
        nxt(); halt_req_i = 1;                        expect_out("jh_flush2",    3'd3, 0, 32'h0,   0, 19);
        nxt(); halt_req_i = 1;                        expect_out("jh_halt",      3'd3, 0, 32'h0,   1, 20);
        nxt();                                        expect_out("jh_release",   3'd3, 0, 32'h0,   1, 21);
        nxt();                                        expect_out("jh_run",       3'd0, 0, 32'h0,   0, 22);

        // Second jump inside FLUSH reloads the counter
        nxt(); jump_flag_i = 1; jump_addr_i = 32'h400; expect_out("jj_first",    3'd3, 1, 32'h400, 0, 22);
        nxt(); jump_flag_i = 1; jump_addr_i = 32'h500; expect_out("jj_second",   3'd3, 1, 32'h500, 0, 23);
        nxt();                                        expect_out("jj_flush1",    3'd3, 0, 32'h0,   0, 24);
        nxt();                                        expect_out("jj_flush2",    3'd3, 0, 32'h0,   0, 25);
        nxt();                                        expect_out("jj_run",       3'd0, 0, 32'h0,   0, 26);

        // Reset in the middle of a flush
        nxt(); jump_flag_i = 1; jump_addr_i = 32'h600; expect_out("rf_jump",     3'd3, 1, 32'h600, 0, 26);
        nxt(); rst = 1'b1;                            expect_out("rf_rst",       3'd3, 0, 32'h0,   0, 27);
        nxt();                                        expect_out("rf_after",     3'd0, 0, 32'h0,   0, 0);
        nxt();                                        expect_out("rf_after2",    3'd0, 0, 32'h0,   0, 0);

`ifdef PIPE_HOLD_WDOG_EN
        for (int i = 1; i <= 10; i++) begin
            nxt(); hold_flag_ex_i = 1;
            expect_out($sformatf("wdog_c%0d", i), 3'd3, 0, 32'h0, 0, i - 1, (i == 8) ? 1'b1 : 1'b0);
        end
        nxt();                                        expect_out("wdog_idle",    3'd0, 0, 32'h0,   0, 10, 1'b0);
`endif

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
